// File: rtl/obc_da_pkg.sv
// Shared types and helpers for the bit-serial OBC distributed-arithmetic engine.
package obc_da_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FIN, DONE} state_t;

    localparam int N_IN_DEF  = 16;
    localparam int GROUP_DEF = 2;
    localparam int NG        = N_IN_DEF / GROUP_DEF;
    localparam int TBL_DEPTH = NG * (2 ** (GROUP_DEF - 1));
    localparam int TBL_AW    = $clog2(TBL_DEPTH);
    localparam int MAX_GROUP = 4;

    typedef struct packed {
        logic                   neg;
        logic [MAX_GROUP-2:0]   addr;
    } fold_t;

    // Fold a group's bit slice onto the half table: address bits are taken
    // relative to sample 0, whose own bit (and the sign plane) decides negation.
    function automatic fold_t obc_fold(input logic [MAX_GROUP-1:0] bits, input logic msb_plane);
        fold_t f;
        f.addr = '0;
        for (int unsigned i = 1; i < MAX_GROUP; i++) begin
            f.addr[i-1] = ~(bits[i] ^ bits[0]);
        end
        f.neg = ~bits[0] ^ msb_plane;
        return f;
    endfunction

endpackage

// File: rtl/obc_da_engine_group_term.sv
// Per-group OBC term: fold the bit slice, read the partial-sum entry, apply sign.
module obc_group_term
    import obc_da_pkg::*;
#(
    parameter int GROUP  = 2,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 48
) (
    input  logic [GROUP-1:0]         i_bits,
    input  logic                     i_msb,
    input  logic signed [COEF_W-1:0] i_tbl [2**(GROUP-1)],
    output logic signed [ACC_W-1:0]  o_term
);

    logic [MAX_GROUP-1:0]     w_bits;
    fold_t                    w_fold;
    logic signed [COEF_W-1:0] w_entry;
    logic signed [ACC_W-1:0]  w_ext;
    logic                     w_unused_addr;

    always_comb begin
        w_bits            = '0;
        w_bits[GROUP-1:0] = i_bits;
        w_fold            = obc_fold(w_bits, i_msb);
        w_entry           = i_tbl[w_fold.addr[GROUP-2:0]];
        // Widen before negating so the most negative entry negates cleanly.
        w_ext             = ACC_W'(w_entry);
        o_term            = w_fold.neg ? -w_ext : w_ext;
    end

    assign w_unused_addr = ^w_fold.addr;

endmodule

// File: rtl/obc_da_engine.sv
// Bit-serial OBC distributed-arithmetic inner-product engine, MSB-first planes.
module obc_da_engine
    import obc_da_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int GROUP  = GROUP_DEF,
    parameter int DATA_W = 16,
    parameter int COEF_W = 32,
    parameter int ACC_W  = 48,
    localparam int L_NG  = N_IN / GROUP,
    localparam int L_ENT = 2 ** (GROUP - 1),
    localparam int L_AW  = $clog2(L_NG * L_ENT),
    localparam int L_PW  = $clog2(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN*DATA_W-1:0]   in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    input  logic                     tbl_we,
    input  logic [L_AW-1:0]          tbl_addr,
    input  logic signed [COEF_W-1:0] tbl_data,
    input  logic                     off_we,
    input  logic signed [COEF_W-1:0] off_data
);

    state_t                   r_state;
    logic                     r_drain;
    logic [L_PW-1:0]          r_plane;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [ACC_W-1:0]  r_psum;
    logic signed [ACC_W-1:0]  r_out_data;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_x [N_IN];
    logic signed [COEF_W-1:0] r_tbl [L_NG][L_ENT];
    logic signed [COEF_W-1:0] r_off;

    logic                     w_accept;
    logic                     w_idle;
    logic                     w_msb;
    logic [GROUP-1:0]         w_bits [L_NG];
    logic signed [ACC_W-1:0]  w_term [L_NG];
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_res;

    assign w_idle    = (r_state == IDLE);
    assign in_ready  = w_idle | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready;
    assign w_msb     = (r_plane == L_PW'(DATA_W - 1));
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign w_res     = r_acc + ACC_W'(r_off);

    always_comb begin
        w_bits = '{default: '0};
        for (int unsigned g = 0; g < L_NG; g++) begin
            for (int unsigned i = 0; i < GROUP; i++) begin
                w_bits[g][i] = r_x[g*GROUP + i][r_plane];
            end
        end
    end

    for (genvar g = 0; g < L_NG; g++) begin : g_term
        obc_group_term #(
            .GROUP  (GROUP),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_term (
            .i_bits (w_bits[g]),
            .i_msb  (w_msb),
            .i_tbl  (r_tbl[g]),
            .o_term (w_term[g])
        );
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned g = 0; g < L_NG; g++) begin
            w_sum = w_sum + w_term[g];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int unsigned k = 0; k < N_IN; k++) begin
                r_x[k] <= in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_idle && tbl_we) begin
            r_tbl[tbl_addr[L_AW-1:GROUP-1]][tbl_addr[GROUP-2:0]] <= tbl_data;
        end
        if (w_idle && off_we) begin
            r_off <= off_data;
        end
    end

    // Plane sums are registered one cycle before accumulation; r_drain marks
    // the extra RUN cycle that folds the plane-0 sum into the accumulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_drain     <= 1'b0;
            r_plane     <= '0;
            r_acc       <= '0;
            r_psum      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (w_accept) begin
            r_state     <= RUN;
            r_drain     <= 1'b0;
            r_plane     <= L_PW'(DATA_W - 1);
            r_acc       <= '0;
            r_psum      <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                RUN: begin
                    r_acc <= (r_acc <<< 1) + r_psum;
                    if (r_drain) begin
                        r_state <= FIN;
                    end else begin
                        r_psum <= w_sum;
                        if (r_plane == '0) r_drain <= 1'b1;
                        else               r_plane <= r_plane - 1'b1;
                    end
                end
                FIN: begin
                    r_out_data  <= w_res >>> 1;
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_obc_da_engine.sv
// Scoreboard bench for obc_da_engine: expected dot products queued at accept time.
module tb_obc_da_engine;

    localparam int N_IN   = 16;
    localparam int GROUP  = 2;
    localparam int DATA_W = 16;
    localparam int COEF_W = 32;
    localparam int ACC_W  = 48;
    localparam int NG     = N_IN / GROUP;
    localparam int ENT    = 2 ** (GROUP - 1);
    localparam int AW     = $clog2(NG * ENT);
    localparam int LAT    = DATA_W + 2;

    typedef logic [ACC_W-1:0] res_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [N_IN*DATA_W-1:0] in_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [ACC_W-1:0]       out_data;
    logic                   tbl_we = 1'b0;
    logic [AW-1:0]          tbl_addr = '0;
    logic [COEF_W-1:0]      tbl_data = '0;
    logic                   off_we = 1'b0;
    logic [COEF_W-1:0]      off_data = '0;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   hs_cnt = 0;
    res_t exp_q[$];
    int   acc_q[$];
    int   coef[N_IN];
    int   xs[N_IN];

    obc_da_engine #(
        .N_IN   (N_IN),
        .GROUP  (GROUP),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .off_we    (off_we),
        .off_data  (off_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: plain dot product of coefficients and samples, modulo 2^ACC_W.
    function automatic res_t model();
        longint s = 0;
        for (int k = 0; k < N_IN; k++) s += longint'(coef[k]) * longint'(xs[k]);
        return res_t'(s);
    endfunction

    task automatic load_tables();
        longint tot = 0;
        for (int g = 0; g < NG; g++) begin
            for (int a = 0; a < ENT; a++) begin
                int t = coef[g*GROUP];
                for (int i = 1; i < GROUP; i++)
                    t += ((a >> (i-1)) & 1) ? coef[g*GROUP+i] : -coef[g*GROUP+i];
                tbl_we   = 1'b1;
                tbl_addr = AW'(g*ENT + a);
                tbl_data = t;
                @(posedge clk); #1;
            end
        end
        tbl_we = 1'b0;
        for (int k = 0; k < N_IN; k++) tot += coef[k];
        off_we   = 1'b1;
        off_data = COEF_W'(-tot);
        @(posedge clk); #1;
        off_we = 1'b0;
    endtask

    task automatic send(output logic was_done);
        was_done = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < N_IN; k++) in_data[k*DATA_W +: DATA_W] = DATA_W'(xs[k]);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                was_done = out_valid;
                exp_q.push_back(model());
                acc_q.push_back(cyc + 1);
                @(posedge clk); #1;
                in_valid = 1'b0;
                for (int k = 0; k < N_IN; k++) in_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
                return;
            end
        end
        fail_now("send_timeout");
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit rand_bp);
        for (int t = 0; t < 400 && exp_q.size() > 0; t++) begin
            out_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
        out_ready = 1'b1;
    endtask

    initial begin : monitor
        logic             prev_v;
        logic [ACC_W-1:0] held;
        int               lat;
        prev_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid && !prev_v) begin
                    held = out_data;
                    if (acc_q.size() == 0) fail_now("latency_no_accept");
                    else begin
                        lat = cyc - acc_q.pop_front();
                        check("latency", 64'(lat), 64'(LAT));
                    end
                end else if (out_valid) begin
                    check("hold_data", out_data, held);
                end
                if (out_valid) check("in_ready_in_done", in_ready, out_ready);
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) fail_now("unexpected_output");
                    else check("result", out_data, exp_q.pop_front());
                end
                prev_v = out_valid;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic bd;
        int   hs0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Unit coefficients: positive and most-negative samples.
        for (int k = 0; k < N_IN; k++) coef[k] = 1;
        load_tables();
        for (int k = 0; k < N_IN; k++) xs[k] = 1;
        send(bd); drain(0);
        for (int k = 0; k < N_IN; k++) xs[k] = -32768;
        send(bd); drain(0);

        // Ramp coefficients, back-to-back pair.
        for (int k = 0; k < N_IN; k++) coef[k] = k;
        load_tables();
        for (int k = 0; k < N_IN; k++) xs[k] = 1;
        send(bd);
        for (int k = 0; k < N_IN; k++) xs[k] = -1;
        send(bd);
        check("b2b_accept_in_done", bd, 1);
        drain(0);

        // Backpressure with ignored in_valid pulses.
        out_ready = 1'b0;
        for (int k = 0; k < N_IN; k++) xs[k] = k - 8;
        send(bd);
        for (int t = 0; t < 100 && !out_valid; t++) begin @(posedge clk); #1; end
        if (!out_valid) fail_now("bp_wait_valid");
        for (int t = 0; t < 5; t++) begin
            in_valid = (t % 2 == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        hs0 = hs_cnt;
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("bp_one_handshake", 64'(hs_cnt - hs0), 1);
        check("bp_queue_empty", 64'(exp_q.size()), 0);
        check("bp_valid_low", out_valid, 0);

        // Table/offset writes while running are ignored.
        for (int k = 0; k < N_IN; k++) xs[k] = 1;
        send(bd);
        for (int a = 0; a < NG*ENT; a++) begin
            tbl_we = 1'b1; tbl_addr = AW'(a); tbl_data = '0;
            off_we = 1'b1; off_data = '0;
            @(posedge clk); #1;
        end
        tbl_we = 1'b0; off_we = 1'b0;
        drain(0);
        send(bd); drain(0);

        // Reset at plane 8, then a fresh vector.
        for (int k = 0; k < N_IN; k++) xs[k] = int'($signed(16'($urandom)));
        send(bd);
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_data", out_data, 0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        load_tables();
        for (int k = 0; k < N_IN; k++) xs[k] = int'($signed(16'($urandom)));
        send(bd); drain(0);

        // Random coefficients and samples with random backpressure.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < N_IN; k++) coef[k] = int'($urandom_range(0, 2**21)) - 2**20;
            load_tables();
            for (int v = 0; v < 6; v++) begin
                for (int k = 0; k < N_IN; k++) begin
                    case ($urandom_range(0, 7))
                        0:       xs[k] = -32768;
                        1:       xs[k] = 32767;
                        default: xs[k] = int'($signed(16'($urandom)));
                    endcase
                end
                send(bd);
                if (v % 2 == 0) drain(1);
            end
            drain(1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
